// File: rtl/gate_checker.sv
// Exhaustive stimulus/response sequencer for small combinational gates: sweeps a
// through 0..2^N-1, samples y after SETTLE cycles and counts mismatches against op.
// Optional first-failure capture: define GATE_CHECKER_FAIL_CAPTURE_EN.
module gate_checker #(
  parameter int N      = 2,
  parameter int SETTLE = 1,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic          y,
  output logic [N-1:0]  a,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_count,
  output logic [N:0]    fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int             SCW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCW-1:0] CNT_INIT = SCW'(SETTLE - 1);
  localparam logic [N-1:0]   A_LAST   = {N{1'b1}};

  state_t          state_q, state_d;
  logic [SCW-1:0]  cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [N-1:0]    a_q, a_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [CW-1:0]   err_q, err_d;
  logic            mismatch_s;
  logic            accept_s;

  function automatic logic golden(input logic [2:0] f, input logic [N-1:0] v);
    logic r;
    case (f)
      3'd0:    r = v[0];
      3'd1:    r = ~v[0];
      3'd2:    r = &v;
      3'd3:    r = |v;
      3'd4:    r = ^v;
      3'd5:    r = ~&v;
      3'd6:    r = ~|v;
      3'd7:    r = ~^v;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign mismatch_s = (y != golden(op_q, a_q));
  assign accept_s   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {SCW{1'b0}};
      op_q    <= 3'd0;
      a_q     <= {N{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_SETTLE;
        else       state_d = state_q;
      end
      S_SETTLE: begin
        if (cnt_q == {SCW{1'b0}}) state_d = S_CHECK;
        else                      state_d = S_SETTLE;
      end
      S_CHECK: begin
        if (a_q == A_LAST) state_d = S_DONE;
        else               state_d = S_SETTLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values; pass uses the count including this CHECK's mismatch.
  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
    err_d  = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_d   = op;
          a_d    = {N{1'b0}};
          err_d  = {CW{1'b0}};
          done_d = 1'b0;
          pass_d = 1'b0;
          busy_d = 1'b1;
          cnt_d  = CNT_INIT;
        end else begin
          cnt_d  = cnt_q;
        end
      end
      S_SETTLE: begin
        if (cnt_q != {SCW{1'b0}}) cnt_d = cnt_q - SCW'(1);
        else                      cnt_d = cnt_q;
      end
      S_CHECK: begin
        if (mismatch_s && !(&err_q)) err_d = err_q + CW'(1);
        else                         err_d = err_q;
        if (a_q == A_LAST) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_d == {CW{1'b0}});
        end else begin
          a_d    = a_q + N'(1);
          cnt_d  = CNT_INIT;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
  logic [N:0] fail_q, fail_d;

  // Only the first mismatch of a sweep is kept; valid bit blocks later overwrites.
  always_comb begin
    fail_d = fail_q;
    if (accept_s) begin
      fail_d = {(N+1){1'b0}};
    end else if ((state_q == S_CHECK) && mismatch_s && !fail_q[N]) begin
      fail_d = {1'b1, a_q};
    end else begin
      fail_d = fail_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) fail_q <= {(N+1){1'b0}};
    else     fail_q <= fail_d;
  end

  assign fail_vec = fail_q;
`else
  assign fail_vec = {(N+1){1'b0}};
`endif

  assign a         = a_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: doc/gate_checker.md
# gate_checker

Self-checking exhaustive stimulus/response sequencer for small combinational gates (gnot and its siblings). It drives the gate-under-test input bus `a` through every pattern 0..2^N-1, waits a settle interval, and samples the gate output `y` against a golden function selected by `op`. It accumulates a mismatch count and reports pass/fail, so gate checks can run as clocked hardware instead of hand-written `initial` sequences.

## Interface
- `N`, 2: gate input width, legal 1..8.
- `SETTLE`, 1: cycles `a` is held before `y` is sampled, legal ≥1.
- `CW`, 8: width of the error counter, legal ≥1.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `start`  input  1  begin a sweep; sampled only in IDLE or DONE.
- `op`  input  3  golden function, latched at start. 0=BUF(a[0]), 1=NOT(~a[0]), 2=&a, 3=|a, 4=^a, 5=~&a, 6=~|a, 7=~^a.
- `y`  input  1  output of the gate under test.
- `a`  output  N  stimulus to the gate under test; registered.
- `busy`  output  1  high from the cycle after start is accepted until DONE is entered.
- `done`  output  1  sweep complete; stays high until the next accepted start or reset.
- `pass`  output  1  valid when done=1; 1 iff err_count==0.
- `err_count`  output  CW  number of mismatches, saturating at 2^CW-1.
- `fail_vec`  output  N+1  first failing pattern: {valid, a}. See Configuration.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- Reset: IDLE; a=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, settle counter=0, latched op=0.
- IDLE/DONE with start=1: latch op, a←0, err_count←0, fail_vec←0, done←0, pass←0, busy←1, settle counter←SETTLE-1, go to SETTLE.
- IDLE/DONE with start=0: hold all outputs.
- SETTLE: if counter==0, go to CHECK; else decrement the counter.
- CHECK: compare y with golden(op, a).
  - On mismatch: err_count←err_count+1 unless already all-ones.
  - On mismatch with fail_vec[N]==0 (macro enabled): fail_vec←{1'b1, a}.
  - If a==2^N-1: go to DONE, busy←0, done←1, pass←(final err_count==0). The final count includes this cycle's mismatch.
  - Otherwise: a←a+1, counter←SETTLE-1, go to SETTLE.
- start while in SETTLE/CHECK is ignored and has no side effect.
- An op change after start is ignored until the next start.
- rst at any cycle, including mid-sweep, aborts to the reset state on that edge.
- `a` never wraps within a sweep. The last pattern is all-ones, then DONE.

## Timing
- Let start be accepted at edge t0. Then a=0 and busy=1 after t0.
- Each pattern occupies exactly SETTLE+1 cycles: SETTLE cycles in SETTLE, 1 in CHECK.
- `y` is sampled at the CHECK-exit edge, SETTLE+1 edges after `a` changed.
- `done` rises at edge t0 + 2^N·(SETTLE+1); busy falls at that same edge.
- From DONE, a new start is accepted on the next edge (back-to-back sweeps allowed). The new sweep clears err_count, pass and fail_vec at its accept edge.
- All outputs are registers; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `GATE_CHECKER_FAIL_CAPTURE_EN`.
- Defined: fail_vec captures {1, a} of the first mismatching pattern in a sweep. Later mismatches do not overwrite it.
- Undefined: the capture logic is not built and fail_vec is tied to 0. The port remains, so instantiations are identical in both builds.

## Test plan
- NOT sweep: N=1, SETTLE=1, op=1, gnot connected (y=~a[0]), start at t0. Required: a goes 0 then 1; done rises at t0+4; pass=1; err_count=0; fail_vec=0.
- Stuck-at-0 gate: N=1, op=1, y tied to 0. Required: err_count=1, pass=0, fail_vec=2'b10 with the macro and 0 without.
- Wrong function: N=2, SETTLE=2, op=2 (AND), y=a[1]|a[0]. Required: mismatches at a=01 and 10; err_count=2; fail_vec=3'b101; done at t0+12.
- Saturation: CW=1, N=2, op=4, y=~^a. Required: err_count=1 (saturated), pass=0.
- Reset mid-run: N=2, assert rst one cycle while a=2'b10 in SETTLE. Required: on the next edge, state is IDLE with a=0, busy=0, done=0, err_count=0.
- Control robustness: pulse start during CHECK and toggle op mid-sweep. Required: the sweep length and result are unchanged. A start while done=1 begins a new sweep at once, with err_count cleared and done low on the next edge.
